// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three result producers (ALU, LSB, MUL) each feed a
// private FIFO; a round-robin scheduler puts one FIFO head per cycle on a registered CDB.
module cdb_arbiter #(
  parameter int ROB_AW = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              alu_valid,
  input  logic [ROB_AW-1:0] alu_robid,
  input  logic [31:0]       alu_val,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [ROB_AW-1:0] lsb_robid,
  input  logic [31:0]       lsb_val,
  output logic              lsb_ready,
  input  logic              mul_valid,
  input  logic [ROB_AW-1:0] mul_robid,
  input  logic [31:0]       mul_val,
  output logic              mul_ready,
  output logic              cdb_valid,
  output logic [ROB_AW-1:0] cdb_robid,
  output logic [31:0]       cdb_val,
  output logic [1:0]        cdb_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = ROB_AW + 32;

  // Handshake: a producer result is taken on an edge where x_valid && x_ready
  // && rdy_in && !clear. x_ready depends only on the registered FIFO count, so
  // a producer that sees ready low must hold its result; it is not captured.

  logic [2:0]          in_valid;
  logic [DW-1:0]       in_data [3];
  logic [CW-1:0]       cnt  [3];
  logic [PW-1:0]       rptr [3];
  logic [PW-1:0]       wptr [3];
  logic [DW-1:0]       mem  [3][DEPTH];
  logic [2:0]          ready;
  logic [2:0]          push;
  logic [2:0]          pop;
  logic                advance;

  logic [1:0]          last;
  logic [1:0]          last_nxt;
  logic                grant_valid;
  logic [1:0]          grant_id;
  logic [DW-1:0]       head;

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  assign in_valid = {mul_valid, lsb_valid, alu_valid};
  assign advance  = rdy_in && !clear;

  always_comb begin
    in_data[0] = {alu_robid, alu_val};
    in_data[1] = {lsb_robid, lsb_val};
    in_data[2] = {mul_robid, mul_val};
  end

  always_comb begin
    ready = '0;
    push  = '0;
    pop   = '0;
    for (int i = 0; i < 3; i++) begin
      ready[i] = cnt[i] < CW'(DEPTH);
      push[i]  = in_valid[i] && ready[i] && advance;
      pop[i]   = grant_valid && (grant_id == 2'(i)) && advance;
    end
  end

  assign alu_ready = ready[0];
  assign lsb_ready = ready[1];
  assign mul_ready = ready[2];

  // Round-robin state register: last granted source.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      last <= 2'd2;
    else if (rdy_in)
      last <= last_nxt;
  end

  always_comb begin
    last_nxt = last;
    if (clear)
      last_nxt = 2'd2;
    else if (grant_valid)
      last_nxt = grant_id;
  end

  // Grant: first non-empty FIFO after the last granted one.
  always_comb begin
    logic [1:0] cand;
    grant_valid = 1'b0;
    grant_id    = 2'd0;
    cand        = last;
    for (int k = 0; k < 3; k++) begin
      cand = rr_next(cand);
      if (!grant_valid && (cnt[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < 3; i++)
      if (grant_id == 2'(i))
        head = mem[i][rptr[i]];
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 3; i++)
      if (push[i])
        mem[i][wptr[i]] <= in_data[i];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || (clear && rdy_in)) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i]  <= '0;
        rptr[i] <= '0;
        wptr[i] <= '0;
      end
      cdb_valid <= 1'b0;
      if (rst_in) begin
        cdb_robid <= '0;
        cdb_val   <= '0;
        cdb_src   <= 2'd0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < 3; i++) begin
        if (push[i])
          wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])
          rptr[i] <= rptr[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_robid <= head[DW-1:32];
        cdb_val   <= head[31:0];
        cdb_src   <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: drivers push hand-computed expected CDB
// beats into a queue; a negedge monitor pops and compares each new broadcast.
module tb_cdb_arbiter;

  localparam int ROB_AW = 4;
  localparam int DEPTH  = 2;
  localparam int W      = 2 + ROB_AW + 32;

  logic              clk_in;
  logic              rst_in;
  logic              rdy_in;
  logic              clear;
  logic              alu_valid, lsb_valid, mul_valid;
  logic [ROB_AW-1:0] alu_robid, lsb_robid, mul_robid;
  logic [31:0]       alu_val, lsb_val, mul_val;
  logic              alu_ready, lsb_ready, mul_ready;
  logic              cdb_valid;
  logic [ROB_AW-1:0] cdb_robid;
  logic [31:0]       cdb_val;
  logic [1:0]        cdb_src;

  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q[$];
  logic       prev_rdy = 1'b0;

  cdb_arbiter #(.ROB_AW(ROB_AW), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .alu_valid(alu_valid), .alu_robid(alu_robid), .alu_val(alu_val), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_robid(lsb_robid), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
    .mul_valid(mul_valid), .mul_robid(mul_robid), .mul_val(mul_val), .mul_ready(mul_ready),
    .cdb_valid(cdb_valid), .cdb_robid(cdb_robid), .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  // Clock / reset block
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_robid = '0; alu_val = '0;
    lsb_valid = 1'b0; lsb_robid = '0; lsb_val = '0;
    mul_valid = 1'b0; mul_robid = '0; mul_val = '0;
  endtask

  task automatic set_src(input int s, input logic [ROB_AW-1:0] tag, input logic [31:0] v);
    case (s)
      0: begin alu_valid = 1'b1; alu_robid = tag; alu_val = v; end
      1: begin lsb_valid = 1'b1; lsb_robid = tag; lsb_val = v; end
      default: begin mul_valid = 1'b1; mul_robid = tag; mul_val = v; end
    endcase
  endtask

  task automatic expect_out(input logic [1:0] s, input logic [ROB_AW-1:0] tag, input logic [31:0] v);
    exp_q.push_back({s, tag, v});
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle_inputs();
    step();
    rst_in = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: a broadcast is new only when the last edge had rdy_in high.
  always @(posedge clk_in) prev_rdy <= rdy_in;

  always @(negedge clk_in) begin
    if (prev_rdy && cdb_valid) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      got = {cdb_src, cdb_robid, cdb_val};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected actual=0x%0h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL cdb_beat actual=0x%0h required=0x%0h", got, want);
        end
      end
    end
  end

  initial begin
    int  ai, li;
    bit  a_acc, l_acc, saw_stall;

    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear  = 1'b0;
    idle_inputs();
    step();
    step();
    rst_in = 1'b0;
    sample();
    chk("reset_valid", 64'(cdb_valid), 64'd0);
    chk("reset_robid", 64'(cdb_robid), 64'd0);
    chk("reset_val",   64'(cdb_val),   64'd0);
    chk("reset_src",   64'(cdb_src),   64'd0);
    chk("reset_ready", 64'({alu_ready, lsb_ready, mul_ready}), 64'b111);

    // Single ALU result: visible exactly two cycles later, for one cycle.
    set_src(0, 4'd3, 32'h11);
    expect_out(2'd0, 4'd3, 32'h11);
    step();
    idle_inputs();
    sample();
    chk("lat_e0_valid", 64'(cdb_valid), 64'd0);
    step();
    sample();
    chk("lat_e1_valid", 64'(cdb_valid), 64'd1);
    step();
    sample();
    chk("lat_e2_valid", 64'(cdb_valid), 64'd0);

    // All three at once after reset: ALU, LSB, MUL order.
    do_reset();
    set_src(0, 4'd1, 32'h0000_0101);
    set_src(1, 4'd2, 32'h0000_0202);
    set_src(2, 4'd3, 32'h0000_0303);
    expect_out(2'd0, 4'd1, 32'h0000_0101);
    expect_out(2'd1, 4'd2, 32'h0000_0202);
    expect_out(2'd2, 4'd3, 32'h0000_0303);
    step();
    idle_inputs();
    drain(10);

    // ALU and LSB stream 4 each; producers hold while ready is low.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_out(2'd0, 4'(i),     32'hA0 + 32'(i));
      expect_out(2'd1, 4'(8 + i), 32'hB0 + 32'(i));
    end
    ai = 0; li = 0; saw_stall = 0;
    for (int cyc = 0; cyc < 20 && (ai < 4 || li < 4); cyc++) begin
      idle_inputs();
      if (ai < 4) set_src(0, 4'(ai),     32'hA0 + 32'(ai));
      if (li < 4) set_src(1, 4'(8 + li), 32'hB0 + 32'(li));
      a_acc = alu_valid && alu_ready;
      l_acc = lsb_valid && lsb_ready;
      if (alu_valid && !alu_ready) saw_stall = 1'b1;
      step();
      if (a_acc) ai++;
      if (l_acc) li++;
    end
    idle_inputs();
    chk("stream_sent", 64'({8'(ai), 8'(li)}), 64'h0404);
    chk("stream_alu_stall", 64'(saw_stall), 64'd1);
    drain(10);

    // Clear with entries queued: only beats granted before clear may appear.
    do_reset();
    set_src(0, 4'd1, 32'h1001);
    set_src(2, 4'd4, 32'h1004);
    expect_out(2'd0, 4'd1, 32'h1001);
    expect_out(2'd2, 4'd4, 32'h1004);
    step();
    idle_inputs();
    set_src(0, 4'd2, 32'h1002);
    set_src(2, 4'd5, 32'h1005);
    step();
    idle_inputs();
    chk("clr_mul_full_ready", 64'(mul_ready), 64'd0);
    set_src(0, 4'd3, 32'h1003);
    step();
    idle_inputs();
    clear = 1'b1;
    set_src(0, 4'd7, 32'h1007);
    set_src(1, 4'd8, 32'h1008);
    step();
    clear = 1'b0;
    idle_inputs();
    sample();
    chk("clr_ready", 64'({alu_ready, lsb_ready, mul_ready}), 64'b111);
    chk("clr_valid", 64'(cdb_valid), 64'd0);
    for (int i = 0; i < 6; i++) step();
    drain(1);

    // rdy_in low freezes outputs; LSB tag 5 goes out after release.
    set_src(0, 4'd9, 32'h2009);
    set_src(1, 4'd5, 32'h2005);
    expect_out(2'd0, 4'd9, 32'h2009);
    expect_out(2'd1, 4'd5, 32'h2005);
    step();
    idle_inputs();
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      sample();
      chk("frz_valid", 64'(cdb_valid), 64'd1);
      chk("frz_beat",  64'({cdb_src, cdb_robid, cdb_val}), 64'({2'd0, 4'd9, 32'h2009}));
      chk("frz_ready", 64'({alu_ready, lsb_ready, mul_ready}), 64'b111);
    end
    rdy_in = 1'b1;
    step();
    sample();
    chk("rel_robid", 64'(cdb_robid), 64'd5);
    chk("rel_valid", 64'(cdb_valid), 64'd1);

    // Reset mid-stream: last=LSB so MUL goes first, then queued work is lost.
    set_src(0, 4'd6, 32'h3006);
    set_src(1, 4'd7, 32'h3007);
    set_src(2, 4'd8, 32'h3008);
    expect_out(2'd2, 4'd8, 32'h3008);
    step();
    idle_inputs();
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    sample();
    chk("mrst_valid", 64'(cdb_valid), 64'd0);
    chk("mrst_ready", 64'({alu_ready, lsb_ready, mul_ready}), 64'b111);
    set_src(0, 4'd11, 32'h4011);
    set_src(1, 4'd12, 32'h4012);
    set_src(2, 4'd13, 32'h4013);
    expect_out(2'd0, 4'd11, 32'h4011);
    expect_out(2'd1, 4'd12, 32'h4012);
    expect_out(2'd2, 4'd13, 32'h4013);
    step();
    idle_inputs();
    drain(10);
    for (int i = 0; i < 4; i++) step();
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
